cond_unit: RTL and testbench

Condition-code unit sitting beside the ALU as the consumer of its N/Z/C/V outputs. Holds the architectural NZCV status register, merges masked flag writebacks, tracks in-flight flag-setting operations and resolves 4-bit condition codes for conditionally executed instructions. Stalls condition requests while flags are pending, forwarding a same-cycle writeback. Supplies the stored carry back to the ALU carry input.

---
 rtl/cond_pkg.sv | 26 ++
 rtl/cond_unit_if.sv | 28 ++
 rtl/cond_eval.sv | 37 +++
 rtl/cond_unit.sv | 67 ++++++
 tb/tb_cond_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code and flag definitions for the condition unit and decode stage.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Flag writeback, condition request and result bundle between the pipeline and cond_unit.
interface cond_unit_if;
   logic       flag_issue;
   logic       flag_we;
   logic [3:0] flag_mask;
   logic       alu_n;
   logic       alu_z;
   logic       alu_c;
   logic       alu_v;
   logic       cond_valid;
   logic [3:0] cond;
   logic       cond_ready;
   logic       exec_valid;
   logic       exec;
   logic [3:0] flags;
   logic       carry;
   logic       pend_err;

   modport master (
      output flag_issue, flag_we, flag_mask, alu_n, alu_z, alu_c, alu_v, cond_valid, cond,
      input  cond_ready, exec_valid, exec, flags, carry, pend_err
   );

   modport slave (
      input  flag_issue, flag_we, flag_mask, alu_n, alu_z, alu_c, alu_v, cond_valid, cond,
      output cond_ready, exec_valid, exec, flags, carry, pend_err
   );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator over an NZCV nibble.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);
   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/cond_unit.sv
// NZCV status register with masked writeback merge, in-flight flag tracking and
// hazard-aware condition resolution with same-cycle writeback forwarding.
module cond_unit
   import cond_pkg::*;
#(
   parameter int unsigned MAX_PEND = 3,
   parameter int unsigned PEND_W   = 2
)
(
   input  logic        clk,
   input  logic        reset,
   cond_unit_if.slave  bus
);
   logic [3:0]        flags_q;
   logic [3:0]        alu_flags;
   logic [3:0]        nflags;
   logic [PEND_W-1:0] pend_cnt;
   logic              inc, dec, overflow, underflow;
   logic              ready, accept, pass;
   logic              exec_valid_q, exec_q, pend_err_q;

   assign alu_flags = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};

   // Forwarded view: masked-off bits come from the register.
   assign nflags = bus.flag_we ? ((bus.flag_mask & alu_flags) | (~bus.flag_mask & flags_q))
                               : flags_q;

   assign inc       = bus.flag_issue & ~bus.flag_we;
   assign dec       = bus.flag_we & ~bus.flag_issue;
   assign overflow  = inc && (pend_cnt == PEND_W'(MAX_PEND));
   assign underflow = dec && (pend_cnt == '0);

   // An issue in the same cycle belongs to a later instruction and never stalls this request.
   assign ready  = (bus.cond == COND_AL) || (bus.cond == COND_NV) || (pend_cnt == '0) ||
                   ((pend_cnt == PEND_W'(1)) && bus.flag_we);
   assign accept = bus.cond_valid & ready;

   cond_eval u_eval (
      .cond (bus.cond),
      .nzcv (nflags),
      .pass (pass)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_q      <= '0;
         pend_cnt     <= '0;
         exec_valid_q <= 1'b0;
         exec_q       <= 1'b0;
         pend_err_q   <= 1'b0;
      end else begin
         flags_q      <= nflags;
         exec_valid_q <= accept;
         if (accept) exec_q <= pass;
         if (overflow || underflow) pend_err_q <= 1'b1;
         else if (inc)              pend_cnt   <= pend_cnt + PEND_W'(1);
         else if (dec)              pend_cnt   <= pend_cnt - PEND_W'(1);
      end
   end

   assign bus.cond_ready = ready;
   assign bus.exec_valid = exec_valid_q;
   assign bus.exec       = exec_q;
   assign bus.flags      = flags_q;
   assign bus.carry      = flags_q[FLAG_C];
   assign bus.pend_err   = pend_err_q;
endmodule

// File: tb/tb_cond_unit.sv
// Directed and randomized checks of cond_unit against a flag-level behavioural model.
module tb_cond_unit;
   import cond_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   cond_unit_if bus ();

   cond_unit #(.MAX_PEND(3), .PEND_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference state
   logic m_n, m_z, m_c, m_v, m_err, m_ev, m_ex;
   int   m_pend;
   logic last_acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Standard ARM pairing: even code tests a base predicate, odd code inverts it.
   function automatic logic ref_cond(input logic [3:0] c, input logic n, input logic z,
                                     input logic cf, input logic v);
      logic base;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic drive(input logic iss, input logic we, input logic [3:0] mask,
                        input logic [3:0] nzcv, input logic vld, input logic [3:0] c);
      bus.flag_issue = iss;
      bus.flag_we    = we;
      bus.flag_mask  = mask;
      {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
      bus.cond_valid = vld;
      bus.cond       = c;
   endtask

   task automatic cycle();
      logic fn, fz, fc, fv, rdy, acc, res, ne, rst_now;
      int   np;
      @(negedge clk);
      fn = (bus.flag_we && bus.flag_mask[3]) ? bus.alu_n : m_n;
      fz = (bus.flag_we && bus.flag_mask[2]) ? bus.alu_z : m_z;
      fc = (bus.flag_we && bus.flag_mask[1]) ? bus.alu_c : m_c;
      fv = (bus.flag_we && bus.flag_mask[0]) ? bus.alu_v : m_v;
      rdy = (bus.cond == 4'hE) || (bus.cond == 4'hF) || (m_pend == 0) ||
            (m_pend == 1 && bus.flag_we);
      check("cond_ready", bus.cond_ready, rdy);
      acc = bus.cond_valid && rdy;
      res = ref_cond(bus.cond, fn, fz, fc, fv);
      np  = m_pend;
      ne  = m_err;
      if (bus.flag_issue && !bus.flag_we) begin
         if (m_pend == 3) ne = 1'b1; else np = m_pend + 1;
      end else if (bus.flag_we && !bus.flag_issue) begin
         if (m_pend == 0) ne = 1'b1; else np = m_pend - 1;
      end
      rst_now = reset;
      @(posedge clk);
      #1;
      if (!rst_now) begin
         {m_n, m_z, m_c, m_v} = 4'b0000;
         m_pend = 0; m_err = 0; m_ev = 0; m_ex = 0;
         last_acc = 1'b0;
      end else begin
         {m_n, m_z, m_c, m_v} = {fn, fz, fc, fv};
         m_pend = np; m_err = ne; m_ev = acc;
         if (acc) m_ex = res;
         last_acc = acc;
      end
      check("flags", bus.flags, {m_n, m_z, m_c, m_v});
      check("carry", bus.carry, m_c);
      check("exec_valid", bus.exec_valid, m_ev);
      check("exec", bus.exec, m_ex);
      check("pend_err", bus.pend_err, m_err);
   endtask

   task automatic do_reset();
      drive(0, 0, 4'h0, 4'h0, 0, COND_AL);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   initial begin
      logic [3:0] c;
      drive(0, 0, 4'h0, 4'h0, 0, COND_AL);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_pend = 0; m_err = 0; m_ev = 0; m_ex = 0; last_acc = 0;
      check("rst_flags", bus.flags, 4'b0000);
      check("rst_ready", bus.cond_ready, 1'b1);
      check("rst_exec_valid", bus.exec_valid, 1'b0);
      reset = 1'b1;

      // EQ on zero flags: accepted, squashed
      drive(0, 0, 4'h0, 4'h0, 1, COND_EQ); cycle();
      check("tp_eq_exec", bus.exec, 1'b0);
      check("tp_eq_valid", bus.exec_valid, 1'b1);

      // Stall then forwarded accept of HI
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(0, 0, 4'h0, 4'h0, 1, COND_HI); cycle();
      check("tp_hi_stall", bus.exec_valid, 1'b0);
      drive(0, 1, 4'hF, 4'b0110, 1, COND_HI); cycle();
      check("tp_hi_valid", bus.exec_valid, 1'b1);
      check("tp_hi_exec", bus.exec, 1'b0);
      check("tp_hi_flags", bus.flags, 4'b0110);

      // flags=1001, partial writeback forwarded into GE
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(0, 1, 4'hF, 4'b1001, 0, COND_AL); cycle();
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(0, 1, 4'b1100, 4'b0100, 1, COND_GE); cycle();
      check("tp_ge_exec", bus.exec, 1'b0);
      check("tp_ge_flags", bus.flags, 4'b0101);

      // AL bypasses pending ops; NE waits for the second writeback
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(0, 0, 4'h0, 4'h0, 1, COND_AL); cycle();
      check("tp_al_exec", bus.exec, 1'b1);
      drive(0, 0, 4'h0, 4'h0, 1, COND_NE); cycle();
      drive(0, 1, 4'h0, 4'h0, 1, COND_NE); cycle();
      check("tp_ne_stall", bus.exec_valid, 1'b0);
      drive(0, 1, 4'b0100, 4'b0000, 1, COND_NE); cycle();
      check("tp_ne_accept", bus.exec_valid, 1'b1);
      check("tp_ne_exec", bus.exec, 1'b1);

      // Overflow and underflow both latch the sticky error
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      end
      check("tp_overflow", bus.pend_err, 1'b1);
      drive(0, 0, 4'h0, 4'h0, 1, COND_EQ); cycle();
      do_reset();
      drive(0, 1, 4'h0, 4'h0, 0, COND_AL); cycle();
      check("tp_underflow", bus.pend_err, 1'b1);
      do_reset();

      // Carry-only writeback, then reset during a stall
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(0, 1, 4'b0010, 4'b1111, 0, COND_AL); cycle();
      check("tp_carry", bus.carry, 1'b1);
      check("tp_carry_flags", bus.flags, 4'b0010);
      drive(1, 0, 4'h0, 4'h0, 0, COND_AL); cycle();
      drive(1, 0, 4'h0, 4'h0, 1, COND_NE); cycle();
      drive(0, 0, 4'h0, 4'h0, 1, COND_NE);
      reset = 1'b0; cycle();
      reset = 1'b1;
      check("tp_rst_flags", bus.flags, 4'b0000);
      check("tp_rst_valid", bus.exec_valid, 1'b0);
      drive(0, 0, 4'h0, 4'h0, 1, COND_NE); cycle();
      check("tp_rst_accept", bus.exec_valid, 1'b1);

      // NV never executes
      drive(0, 0, 4'h0, 4'h0, 1, COND_NV); cycle();
      check("tp_nv_exec", bus.exec, 1'b0);

      // Randomized traffic; a stalled request is held unchanged until accepted
      for (int i = 0; i < 600; i++) begin
         logic iss, we, vld;
         iss = ($urandom_range(0, 2) == 0) && (m_pend < 3 || $urandom_range(0, 40) == 0);
         we  = ($urandom_range(0, 2) == 0) && (m_pend > 0 || $urandom_range(0, 40) == 0);
         if (bus.cond_valid && !last_acc && reset) begin
            vld = 1'b1;
            c   = bus.cond;
         end else begin
            vld = ($urandom_range(0, 1) == 1);
            c   = 4'($urandom_range(0, 15));
         end
         drive(iss, we, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), vld, c);
         reset = ($urandom_range(0, 79) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
